// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle MIPS control unit. A registered FSM sequences each instruction
//   through FETCH/DECODE/EXEC/(MUL)/(MEM)/WB. It handshakes with instruction and
//   data memory over req/ack and holds multiply instructions in EXEC+MUL for
//   MUL_CYCLES cycles. A missing ack raises a sticky bus_err and the FSM parks
//   in ERR until Rst.
//
// Optional feature: define ILLEGAL_TRAP_EN to trap unlisted opcodes in state 7
//   and expose the illegal_op port. Without it, unlisted opcodes run as NOPs.
//
// Ports
//   Clk, Rst              clock, synchronous active-high reset
//   opcode, funct         instruction fields, sampled in DECODE
//   imem_ack, dmem_ack    memory completion strobes
//   imem_req, dmem_req    memory requests
//   ir_write, pc_write    IR / PC+4 latch strobes (on imem_ack)
//   reg_dst, alu_src, mem_to_reg, zero_extend, mul_op   datapath selects
//   reg_write             register-file write strobe (WB only)
//   mem_read, mem_write   qualify dmem_req
//   branch_jump           branch class
//   alu_op                ALU function
//   mem_data_type         00 byte, 01 half, 10 word
//   state                 current FSM state (debug)
//   bus_err               sticky memory-timeout flag
//   illegal_op            (ILLEGAL_TRAP_EN only) high while in TRAP
module multicycle_controller #(
    parameter int ALUOP_W      = 5,
    parameter int MUL_CYCLES   = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               zero_extend,
    output logic               mul_op,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [2:0]         branch_jump,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         mem_data_type,
    output logic [2:0]         state,
    output logic               bus_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam int MUL_W  = $clog2(MUL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MUL    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP   = 3'd7
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_SPEC2  = 6'b011100;
    localparam logic [5:0] OP_SPEC3  = 6'b011111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    function automatic logic f_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_SPEC2, OP_SPEC3, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW:
                f_legal = 1'b1;
            default:
                f_legal = 1'b0;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_opcode;
    logic [5:0]          r_funct;
    logic                r_legal;
    logic [WAIT_W-1:0]   r_wait;
    logic [MUL_W-1:0]    r_mul_cnt;
    logic                r_bus_err;

    logic                w_timeout;
    logic                w_wait_last;
    logic                w_mul_last;
    logic                w_load;
    logic                w_store;
    logic                w_ialu;
    logic                w_mul;
    logic                w_zext;
    logic [2:0]          w_bj;
    logic [4:0]          w_aluop;
    logic [1:0]          w_dtype;
    logic                w_ctl_active;

    // r_wait holds the number of completed wait cycles, so the current
    // cycle is r_wait+1; the last acceptable cycle is MEM_WAIT_MAX.
    assign w_wait_last = (r_wait == WAIT_W'(MEM_WAIT_MAX - 1));
    // EXEC counts as the first multiply cycle; r_mul_cnt starts at 1 in MUL.
    assign w_mul_last  = (r_mul_cnt == MUL_W'(MUL_CYCLES - 1));

    // Decode of the latched instruction fields.
    always_comb begin
        w_load  = (r_opcode == OP_LB) || (r_opcode == OP_LH) || (r_opcode == OP_LW);
        w_store = (r_opcode == OP_SB) || (r_opcode == OP_SH) || (r_opcode == OP_SW);
        w_ialu  = (r_opcode == OP_ADDI) || (r_opcode == OP_ADDIU) ||
                  (r_opcode == OP_SLTI) || (r_opcode == OP_SLTIU) ||
                  (r_opcode == OP_ANDI) || (r_opcode == OP_ORI)   ||
                  (r_opcode == OP_XORI) || (r_opcode == OP_LUI);
        w_mul   = ((r_opcode == OP_RTYPE) &&
                   ((r_funct == 6'b011000) || (r_funct == 6'b011001))) ||
                  (r_opcode == OP_SPEC2);
        w_zext  = (r_opcode == OP_ANDI) || (r_opcode == OP_ORI) ||
                  (r_opcode == OP_XORI) || (r_opcode == OP_SLTIU);

        w_aluop = 5'b00000;
        case (r_opcode)
            OP_ADDI, OP_LW, OP_SW, OP_LB, OP_LH, OP_SB, OP_SH, OP_LUI:
                      w_aluop = 5'b00010;
            OP_ADDIU: w_aluop = 5'b00111;
            OP_ANDI:  w_aluop = 5'b00001;
            OP_ORI:   w_aluop = 5'b00011;
            OP_XORI:  w_aluop = 5'b00100;
            OP_SLTI:  w_aluop = 5'b00101;
            OP_SLTIU: w_aluop = 5'b01011;
            OP_SPEC2: w_aluop = 5'b01000;
            OP_SPEC3: w_aluop = 5'b01001;
            OP_BEQ, OP_BNE:
                      w_aluop = 5'b00110;
            default:  w_aluop = 5'b00000;
        endcase

        w_bj = 3'b000;
        case (r_opcode)
            OP_BEQ:        w_bj = 3'b001;
            OP_BNE:        w_bj = 3'b010;
            OP_J, OP_JAL:  w_bj = 3'b011;
            OP_REGIMM:     w_bj = 3'b100;
            OP_BGTZ:       w_bj = 3'b101;
            OP_BLEZ:       w_bj = 3'b110;
            default:       w_bj = 3'b000;
        endcase

        w_dtype = 2'b00;
        case (r_opcode)
            OP_LH, OP_SH: w_dtype = 2'b01;
            OP_LW, OP_SW: w_dtype = 2'b10;
            default:      w_dtype = 2'b00;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_next = S_DECODE;
                end else if (w_wait_last) begin
                    w_next    = S_ERR;
                    w_timeout = 1'b1;
                end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                if (!f_legal(opcode)) w_next = S_TRAP;
                else                  w_next = S_EXEC;
`else
                w_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (w_mul)                  w_next = (MUL_CYCLES <= 1) ? S_WB : S_MUL;
                else if (w_bj != 3'b000)    w_next = S_FETCH;
                else if (w_load || w_store) w_next = S_MEM;
                else                        w_next = S_WB;
            end
            S_MUL: begin
                if (w_mul_last) w_next = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    w_next = w_store ? S_FETCH : S_WB;
                end else if (w_wait_last) begin
                    w_next    = S_ERR;
                    w_timeout = 1'b1;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_ERR:   w_next = S_ERR;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:  w_next = S_TRAP;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_legal   <= 1'b0;
            r_wait    <= '0;
            r_mul_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any state change restarts the wait count, which covers entry
            // into FETCH and MEM; the count only advances while waiting.
            if (w_next != r_state)
                r_wait <= '0;
            else if ((r_state == S_FETCH) || (r_state == S_MEM))
                r_wait <= r_wait + WAIT_W'(1);
            if (r_state == S_EXEC)
                r_mul_cnt <= MUL_W'(1);
            else if (r_state == S_MUL)
                r_mul_cnt <= r_mul_cnt + MUL_W'(1);
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
                r_funct  <= funct;
                r_legal  <= f_legal(opcode);
            end
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    assign w_ctl_active = (r_state == S_EXEC) || (r_state == S_MUL) ||
                          (r_state == S_MEM)  || (r_state == S_WB);

    // Outputs. Rst masks every strobe in the cycle it is sampled.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        zero_extend   = 1'b0;
        mul_op        = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch_jump   = 3'b000;
        alu_op        = '0;
        mem_data_type = 2'b00;
        if (!Rst) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                    pc_write = imem_ack;
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = w_load;
                    mem_write = w_store;
                end
                S_WB:    reg_write = r_legal;
                default: ;
            endcase
            if (w_ctl_active) begin
                reg_dst       = w_ialu || (r_opcode == OP_LW);
                alu_src       = w_ialu || w_load || w_store;
                mem_to_reg    = !w_load;
                zero_extend   = w_zext;
                mul_op        = w_mul;
                branch_jump   = w_bj;
                alu_op        = ALUOP_W'(w_aluop);
                mem_data_type = w_dtype;
            end
        end
    end

    assign state   = r_state;
    assign bus_err = r_bus_err;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed-vector bench for multicycle_controller with MUL_CYCLES=4 and
//   MEM_WAIT_MAX=15. Inputs change and outputs are sampled just after the
//   falling edge.
module tb_multicycle_controller;

    logic       Clk;
    logic       Rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       zero_extend;
    logic       mul_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] branch_jump;
    logic [4:0] alu_op;
    logic [1:0] mem_data_type;
    logic [2:0] state;
    logic       bus_err;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_checks;
    int n_fail;

    multicycle_controller #(
        .ALUOP_W(5),
        .MUL_CYCLES(4),
        .MEM_WAIT_MAX(15)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .opcode(opcode),
        .funct(funct),
        .imem_ack(imem_ack),
        .dmem_ack(dmem_ack),
        .imem_req(imem_req),
        .dmem_req(dmem_req),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .reg_dst(reg_dst),
        .alu_src(alu_src),
        .mem_to_reg(mem_to_reg),
        .zero_extend(zero_extend),
        .mul_op(mul_op),
        .reg_write(reg_write),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .branch_jump(branch_jump),
        .alu_op(alu_op),
        .mem_data_type(mem_data_type),
        .state(state),
        .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    // Called in a FETCH cycle; returns in the DECODE cycle with opcode held.
    task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode   = op;
        funct    = fn;
        imem_ack = 1'b1;
        #1;
        check("fetch_ir_write", 32'(ir_write), 32'd1);
        check("fetch_pc_write", 32'(pc_write), 32'd1);
        cyc();
        imem_ack = 1'b0;
        #1;
        check("decode_state", 32'(state), 32'd1);
    endtask

    logic [5:0] t_op  [7];
    logic [4:0] t_alu [7];
    logic       t_ze  [7];

    initial begin
        int  n;
        bit  done;
        t_op[0] = 6'b001001; t_alu[0] = 5'b00111; t_ze[0] = 1'b0; // addiu
        t_op[1] = 6'b001100; t_alu[1] = 5'b00001; t_ze[1] = 1'b1; // andi
        t_op[2] = 6'b001101; t_alu[2] = 5'b00011; t_ze[2] = 1'b1; // ori
        t_op[3] = 6'b001110; t_alu[3] = 5'b00100; t_ze[3] = 1'b1; // xori
        t_op[4] = 6'b001010; t_alu[4] = 5'b00101; t_ze[4] = 1'b0; // slti
        t_op[5] = 6'b001011; t_alu[5] = 5'b01011; t_ze[5] = 1'b1; // sltiu
        t_op[6] = 6'b001111; t_alu[6] = 5'b00010; t_ze[6] = 1'b0; // lui

        n_checks = 0;
        n_fail   = 0;
        Rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opcode   = '0;
        funct    = '0;

        // Reset state
        cyc(); cyc(); #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_mem_to_reg", 32'(mem_to_reg), 32'd0);
        Rst = 1'b0;
        cyc(); #1;
        check("fetch_state", 32'(state), 32'd0);
        check("fetch_imem_req", 32'(imem_req), 32'd1);

        // addi: FETCH, DECODE, EXEC, WB
        do_fetch(6'b001000, 6'b000000);
        check("addi_dec_reg_write", 32'(reg_write), 32'd0);
        cyc(); #1;
        check("addi_exec_state", 32'(state), 32'd2);
        check("addi_alu_op", 32'(alu_op), 32'h02);
        check("addi_alu_src", 32'(alu_src), 32'd1);
        check("addi_reg_dst", 32'(reg_dst), 32'd1);
        check("addi_exec_reg_write", 32'(reg_write), 32'd0);
        cyc(); #1;
        check("addi_wb_state", 32'(state), 32'd5);
        check("addi_wb_reg_write", 32'(reg_write), 32'd1);
        cyc(); #1;
        check("addi_end_state", 32'(state), 32'd0);
        check("addi_end_reg_write", 32'(reg_write), 32'd0);

        // I-type ALU decode table
        for (int i = 0; i < 7; i++) begin
            do_fetch(t_op[i], 6'b000000);
            cyc(); #1;
            check($sformatf("ialu%0d_alu_op", i), 32'(alu_op), 32'(t_alu[i]));
            check($sformatf("ialu%0d_zext", i), 32'(zero_extend), 32'(t_ze[i]));
            cyc(); #1;
            check($sformatf("ialu%0d_wb", i), 32'(reg_write), 32'd1);
            cyc(); #1;
        end

        // beq: one EXEC cycle then FETCH
        do_fetch(6'b000100, 6'b000000);
        cyc(); #1;
        check("beq_bj", 32'(branch_jump), 32'd1);
        check("beq_alu_op", 32'(alu_op), 32'h06);
        cyc(); #1;
        check("beq_next_state", 32'(state), 32'd0);

        // lw with dmem_ack after 3 waiting cycles
        do_fetch(6'b100011, 6'b000000);
        cyc(); #1;
        check("lw_exec_state", 32'(state), 32'd2);
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
            check("lw_mem_wait_state", 32'(state), 32'd4);
            check("lw_mem_wait_rw", 32'(reg_write), 32'd0);
        end
        check("lw_dmem_req", 32'(dmem_req), 32'd1);
        check("lw_mem_read", 32'(mem_read), 32'd1);
        check("lw_mem_write", 32'(mem_write), 32'd0);
        check("lw_dtype", 32'(mem_data_type), 32'd2);
        check("lw_mem_to_reg", 32'(mem_to_reg), 32'd0);
        cyc(); dmem_ack = 1'b1; #1;
        check("lw_ack_state", 32'(state), 32'd4);
        cyc(); dmem_ack = 1'b0; #1;
        check("lw_wb_state", 32'(state), 32'd5);
        check("lw_wb_reg_write", 32'(reg_write), 32'd1);
        cyc(); #1;
        check("lw_end_state", 32'(state), 32'd0);

        // mul: EXEC+MUL span is MUL_CYCLES
        do_fetch(6'b000000, 6'b011000);
        cyc(); #1;
        check("mul_exec_state", 32'(state), 32'd2);
        check("mul_op_exec", 32'(mul_op), 32'd1);
        n = 1;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            cyc(); #1;
            if (state == 3'd3) n++;
            else done = 1'b1;
        end
        check("mul_cycles", 32'(n), 32'd4);
        check("mul_wb_state", 32'(state), 32'd5);
        check("mul_wb_reg_write", 32'(reg_write), 32'd1);
        cyc(); #1;

        // sw with no ack: timeout after 15 MEM cycles
        do_fetch(6'b101011, 6'b000000);
        cyc(); #1;
        for (int i = 1; i <= 15; i++) begin
            cyc(); #1;
            if (i == 1) begin
                check("sw_mem_write", 32'(mem_write), 32'd1);
                check("sw_mem_read", 32'(mem_read), 32'd0);
                check("sw_dtype", 32'(mem_data_type), 32'd2);
            end
        end
        check("sw_c15_state", 32'(state), 32'd4);
        check("sw_c15_bus_err", 32'(bus_err), 32'd0);
        cyc(); #1;
        check("to_state", 32'(state), 32'd6);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_dmem_req", 32'(dmem_req), 32'd0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        cyc(); #1;
        check("err_hold_state", 32'(state), 32'd6);
        check("err_ir_write", 32'(ir_write), 32'd0);
        check("err_imem_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        Rst = 1'b1;
        cyc(); #1;
        check("err_rst_state", 32'(state), 32'd0);
        check("err_rst_bus_err", 32'(bus_err), 32'd0);
        cyc(); Rst = 1'b0; #1;
        check("err_rst_fetch", 32'(imem_req), 32'd1);

        // sw with ack on the last allowed cycle
        do_fetch(6'b101011, 6'b000000);
        cyc(); #1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (i == 15) dmem_ack = 1'b1;
            #1;
        end
        check("sw15_state", 32'(state), 32'd4);
        check("sw15_dmem_req", 32'(dmem_req), 32'd1);
        cyc(); dmem_ack = 1'b0; #1;
        check("sw15_next_state", 32'(state), 32'd0);
        check("sw15_bus_err", 32'(bus_err), 32'd0);

        // Rst held two cycles mid-MEM
        do_fetch(6'b100011, 6'b000000);
        cyc(); #1;
        cyc(); #1;
        cyc(); #1;
        check("mid_mem_state", 32'(state), 32'd4);
        Rst = 1'b1;
        cyc(); #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_dmem_req", 32'(dmem_req), 32'd0);
        check("midrst_mem_read", 32'(mem_read), 32'd0);
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_alu_src", 32'(alu_src), 32'd0);
        cyc(); #1;
        check("midrst2_state", 32'(state), 32'd0);
        Rst = 1'b0;
        cyc(); #1;
        check("midrst_fetch", 32'(imem_req), 32'd1);

        // Unlisted opcode
        do_fetch(6'b111111, 6'b000000);
`ifdef ILLEGAL_TRAP_EN
        cyc(); #1;
        check("trap_state", 32'(state), 32'd7);
        check("trap_illegal_op", 32'(illegal_op), 32'd1);
        cyc(); cyc(); #1;
        check("trap_hold_state", 32'(state), 32'd7);
        check("trap_reg_write", 32'(reg_write), 32'd0);
        check("trap_dmem_req", 32'(dmem_req), 32'd0);
`else
        cyc(); #1;
        check("nop_exec_state", 32'(state), 32'd2);
        check("nop_exec_rw", 32'(reg_write), 32'd0);
        cyc(); #1;
        check("nop_wb_state", 32'(state), 32'd5);
        check("nop_wb_rw", 32'(reg_write), 32'd0);
        cyc(); #1;
        check("nop_end_state", 32'(state), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
